// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the hazard scoreboard.
package hazard_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] ready_cnt_t;

  localparam int LOAD_LAT_DEF = 2;
  localparam int MD_LAT_DEF   = 8;
  localparam int STAT_W       = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Loadable down-counter that reports busy while its count is nonzero.
module md_busy_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight load destinations and the mul/div unit; stalls ID when an operand is not forwardable.
// Optional stall statistics ports are enabled with HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MD_LAT   = MD_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  reg_idx_t         id_rs,
  input  reg_idx_t         id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_reads_hilo,
  input  logic             issue_valid,
  input  reg_idx_t         issue_dst,
  input  logic             issue_we,
  input  logic             issue_is_load,
  input  logic             issue_is_md,
  input  logic             flush,
`ifdef HAZARD_SCOREBOARD_STATS_EN
  output logic [STAT_W-1:0] stat_load_stalls_o,
  output logic [STAT_W-1:0] stat_md_stalls_o,
`endif
  output logic             stall_o,
  output logic             md_busy_o,
  output logic [NREGS-1:0] pend_o
);

  localparam int MD_W = $clog2(MD_LAT + 1);

  ready_cnt_t cnt [NREGS];
  ready_cnt_t rs_cnt;
  ready_cnt_t rt_cnt;
  logic       gpr_stall;
  logic       md_stall;
  logic       iss;

  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (id_rs == reg_idx_t'(i)) rs_cnt = cnt[i];
      if (id_rt == reg_idx_t'(i)) rt_cnt = cnt[i];
    end
  end

  // A count of 1 means the load result sits in MEM_WB this cycle and is forwardable,
  // so only counts above 1 block the consumer.
  assign gpr_stall = (id_rs_used && (id_rs != '0) && (rs_cnt > ready_cnt_t'(1))) ||
                     (id_rt_used && (id_rt != '0) && (rt_cnt > ready_cnt_t'(1)));
  assign md_stall  = id_reads_hilo && md_busy_o;

  // issue_valid is a request: the ID instruction moves to EXE only in a cycle where
  // stall_o is low and flush is low; otherwise the attempt leaves no state behind.
  assign stall_o = !flush && (gpr_stall || md_stall);
  assign iss     = issue_valid && !stall_o && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == 0) begin
          cnt[i] <= '0;
        end else if (iss && issue_we && (issue_dst == reg_idx_t'(i))) begin
          cnt[i] <= issue_is_load ? ready_cnt_t'(LOAD_LAT) : '0;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - ready_cnt_t'(1);
        end
      end
    end
  end

  always_comb begin
    pend_o = '0;
    for (int i = 1; i < NREGS; i++) pend_o[i] = (cnt[i] != '0);
  end

  md_busy_timer #(
    .W (MD_W)
  ) u_md_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (iss && issue_is_md),
    .load_val (MD_W'(MD_LAT)),
    .busy     (md_busy_o)
  );

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [STAT_W-1:0] load_stalls_q;
  logic [STAT_W-1:0] md_stalls_q;

  // GPR stalls take precedence; the mul/div counter sees only pure HI/LO stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stalls_q <= '0;
      md_stalls_q   <= '0;
    end else if (stall_o) begin
      if (gpr_stall) load_stalls_q <= sat_inc(load_stalls_q);
      else           md_stalls_q   <= sat_inc(md_stalls_q);
    end
  end

  assign stat_load_stalls_o = load_stalls_q;
  assign stat_md_stalls_o   = md_stalls_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard: driver pushes expectations, monitor compares at negedge.
module tb_hazard_scoreboard;

  localparam int W = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_rs_used = 1'b0;
  logic        id_rt_used = 1'b0;
  logic        id_reads_hilo = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_dst = '0;
  logic        issue_we = 1'b0;
  logic        issue_is_load = 1'b0;
  logic        issue_is_md = 1'b0;
  logic        flush = 1'b0;
  logic        stall_o;
  logic        md_busy_o;
  logic [31:0] pend_o;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stat_load_stalls_o;
  logic [31:0] stat_md_stalls_o;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_used    (id_rs_used),
    .id_rt_used    (id_rt_used),
    .id_reads_hilo (id_reads_hilo),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .issue_we      (issue_we),
    .issue_is_load (issue_is_load),
    .issue_is_md   (issue_is_md),
    .flush         (flush),
`ifdef HAZARD_SCOREBOARD_STATS_EN
    .stat_load_stalls_o (stat_load_stalls_o),
    .stat_md_stalls_o   (stat_md_stalls_o),
`endif
    .stall_o       (stall_o),
    .md_busy_o     (md_busy_o),
    .pend_o        (pend_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d vectors pending", exp_q.size());
    $fatal(1);
  end

  // driver: applies one cycle of ID/issue inputs and queues the expected outputs
  task automatic drive(input string nm,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic hilo, input logic iv, input logic [4:0] dst,
                       input logic we, input logic ld, input logic md, input logic fl,
                       input logic es, input logic eb, input logic [31:0] ep);
    @(posedge clk);
    #1;
    id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_reads_hilo = hilo; issue_valid = iv; issue_dst = dst;
    issue_we = we; issue_is_load = ld; issue_is_md = md; flush = fl;
    name_q.push_back(nm);
    exp_q.push_back({es, eb, ep});
  endtask

  task automatic idle(input string nm, input logic es, input logic eb, input logic [31:0] ep);
    drive(nm, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, es, eb, ep);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] got_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {stall_o, md_busy_o, pend_o};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL %s: got stall=%0b busy=%0b pend=%h, expected stall=%0b busy=%0b pend=%h",
                 nm, got_v[33], got_v[32], got_v[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset while a load is pending
    drive("rst_lw5", 0,0, 0,0, 0, 1,5,1,1,0,0, 0,0,32'h0);
    idle ("rst_pend5", 0,0,32'h20);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive("rst_clear", 5,1, 5,1, 0, 0,0,0,0,0,0, 0,0,32'h0);

    // load-use
    drive("lu_lw8",   0,0, 0,0, 0, 1,8,1,1,0,0,  0,0,32'h0);
    drive("lu_stall", 8,1, 0,0, 0, 1,10,1,0,0,0, 1,0,32'h100);
    drive("lu_issue", 8,1, 0,0, 0, 1,10,1,0,0,0, 0,0,32'h100);
    drive("lu_clear", 8,1, 0,0, 0, 0,0,0,0,0,0,  0,0,32'h0);

    // ALU producer
    drive("alu_add9",  0,0, 0,0, 0, 1,9,1,0,0,0,  0,0,32'h0);
    drive("alu_use9",  0,0, 9,1, 0, 1,11,1,0,0,0, 0,0,32'h0);
    drive("alu_idle9", 0,0, 9,1, 0, 0,0,0,0,0,0,  0,0,32'h0);

    // $zero is never tracked
    drive("zero_lw0", 0,0, 0,0, 0, 1,0,1,1,0,0, 0,0,32'h0);
    drive("zero_use", 0,1, 0,1, 0, 0,0,0,0,0,0, 0,0,32'h0);

    // mul/div then mfhi
    drive("md_mult", 0,0, 0,0, 1, 1,0,0,0,1,0, 0,0,32'h0);
    for (int i = 0; i < 8; i++)
      drive("md_mfhi_stall", 0,0, 0,0, 1, 1,12,1,0,0,0, 1,1,32'h0);
    drive("md_mfhi_go", 0,0, 0,0, 1, 1,12,1,0,0,0, 0,0,32'h0);

    // independent instruction while mul/div busy
    drive("md_mult2",     0,0, 0,0, 1, 1,0,0,0,1,0,  0,0,32'h0);
    drive("md_indep_add", 3,1, 0,0, 0, 1,13,1,0,0,0, 0,1,32'h0);
    for (int i = 0; i < 7; i++) idle("md_busy_tail", 0,1,32'h0);
    idle("md_done", 0,0,32'h0);

    // flush
    drive("fl_lw4",    0,0, 0,0, 0, 1,4,1,1,0,1, 0,0,32'h0);
    idle ("fl_none", 0,0,32'h0);
    drive("fl_lw6",    0,0, 0,0, 0, 1,6,1,1,0,0, 0,0,32'h0);
    drive("fl_force0", 6,1, 0,0, 0, 1,7,1,1,0,1, 0,0,32'h40);
    drive("fl_dec6",   6,1, 0,0, 0, 0,0,0,0,0,0, 0,0,32'h40);
    idle ("fl_no7", 0,0,32'h0);

    // WAW overwrite
    drive("waw_lw4",   0,0, 0,0, 0, 1,4,1,1,0,0,  0,0,32'h0);
    drive("waw_addu4", 0,0, 0,0, 0, 1,4,1,0,0,0,  0,0,32'h10);
    drive("waw_use4",  4,1, 0,0, 0, 1,14,1,0,0,0, 0,0,32'h0);

    // issue and decrement on different registers in the same cycle
    drive("par_lw20",    0,0,  0,0,  0, 1,20,1,1,0,0, 0,0,32'h0);
    drive("par_lw21",    0,0,  0,0,  0, 1,21,1,1,0,0, 0,0,32'h0010_0000);
    drive("par_rt21",    20,1, 21,1, 0, 1,15,1,0,0,0, 1,0,32'h0030_0000);
    drive("par_rt21_ok", 20,1, 21,1, 0, 1,15,1,0,0,0, 0,0,32'h0020_0000);
    idle ("par_clear", 0,0,32'h0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors never compared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
